// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: stream ports of the radix-2 butterfly.
// slave is the butterfly side, master is the producer/consumer side.
interface butterfly_pipe_if #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int TAG_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2*DW-1:0]   in_a;
  logic [2*DW-1:0]   in_b;
  logic [2*TW-1:0]   in_w;
  logic              in_dif;
  logic              in_inv;
  logic              in_scale;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*DW-1:0]   out_a;
  logic [2*DW-1:0]   out_b;
  logic [TAG_W-1:0]  out_tag;
  logic              out_sat;
  logic              sat_sticky;
  logic              sat_clr;

  modport slave (
    input  in_valid, in_a, in_b, in_w, in_dif, in_inv,
    input  in_scale, in_tag, out_ready, sat_clr,
    output in_ready, out_valid, out_a, out_b, out_tag,
    output out_sat, sat_sticky
  );

  modport master (
    output in_valid, in_a, in_b, in_w, in_dif, in_inv,
    output in_scale, in_tag, out_ready, sat_clr,
    input  in_ready, out_valid, out_a, out_b, out_tag,
    input  out_sat, sat_sticky
  );
endinterface

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 4-stage fixed-point radix-2 FFT butterfly with
// DIT/DIF per sample, conjugate twiddle, 1/2 scaling, saturation flags.
module butterfly_pipe #(
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int TAG_W = 8
) (
  input logic             clk,
  input logic             areset_n,
  butterfly_pipe_if.slave bus
);
  localparam int XW = DW + 1;
  localparam int WW = TW + 1;
  localparam int PW = XW + WW;
  localparam int SW = PW + 1;
  localparam int RW = DW + 3;
  localparam int OW = RW + 1;

  localparam logic signed [SW-1:0] RND = SW'(2 ** (TW - 2));
  localparam logic signed [OW-1:0] HI  = OW'((2 ** (DW - 1)) - 1);
  localparam logic signed [OW-1:0] LO  = ~HI;
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

  // {saturated, value}
  function automatic logic [DW:0] clamp(input logic signed [OW-1:0] x);
    if (x > HI) return {1'b1, MAXV};
    if (x < LO) return {1'b1, MINV};
    return {1'b0, x[DW-1:0]};
  endfunction

  function automatic logic [DW:0] conv(
    input logic signed [OW-1:0] x,
    input logic                 sc
  );
    logic signed [OW-1:0] h;
    h = (x + OW'(1)) >>> 1;
    return clamp(sc ? h : x);
  endfunction

  logic en;
  logic v1, v2, v3, v4;

  logic signed [DW-1:0] ar, ai, br, bi;
  logic signed [TW-1:0] wr, wi;

  logic                    dif1, sc1;
  logic [TAG_W-1:0]        tag1;
  logic signed [XW-1:0]    x1r, x1i, p1r, p1i;
  logic signed [WW-1:0]    w1r, w1i;

  logic                    dif2, sc2;
  logic [TAG_W-1:0]        tag2;
  logic signed [PW-1:0]    rr2, ii2, ri2, ir2;
  logic signed [XW-1:0]    p2r, p2i;

  logic                    dif3, sc3, s3;
  logic [TAG_W-1:0]        tag3;
  logic signed [RW-1:0]    t3r, t3i;
  logic signed [XW-1:0]    p3r, p3i;

  logic signed [SW-1:0]    re_s, im_s;
  logic signed [RW-1:0]    re_r, im_r;
  logic [DW:0]             c_re, c_im;

  logic signed [OW-1:0]    ya_r, ya_i, yb_r, yb_i;
  logic [DW:0]             ca_r, ca_i, cb_r, cb_i;

  logic [2*DW-1:0]         oa, ob;
  logic [TAG_W-1:0]        otag;
  logic                    osat, sticky;

  assign en = !v4 || bus.out_ready;
  assign bus.in_ready = en;

  assign ar = $signed(bus.in_a[2*DW-1:DW]);
  assign ai = $signed(bus.in_a[DW-1:0]);
  assign br = $signed(bus.in_b[2*DW-1:DW]);
  assign bi = $signed(bus.in_b[DW-1:0]);
  assign wr = $signed(bus.in_w[2*TW-1:TW]);
  assign wi = $signed(bus.in_w[TW-1:0]);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      {v1, v2, v3, v4} <= '0;
    end else if (en) begin
      {v1, v2, v3, v4} <= {bus.in_valid, v1, v2, v3};
    end
  end

  // S1: DIF pre-add, twiddle conjugation at TW+1 bits
  always_ff @(posedge clk) begin
    if (en) begin
      dif1 <= bus.in_dif;
      sc1  <= bus.in_scale;
      tag1 <= bus.in_tag;
      x1r  <= bus.in_dif ? XW'(ar) - XW'(br) : XW'(br);
      x1i  <= bus.in_dif ? XW'(ai) - XW'(bi) : XW'(bi);
      p1r  <= bus.in_dif ? XW'(ar) + XW'(br) : XW'(ar);
      p1i  <= bus.in_dif ? XW'(ai) + XW'(bi) : XW'(ai);
      w1r  <= WW'(wr);
      w1i  <= bus.in_inv ? -WW'(wi) : WW'(wi);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      dif2 <= dif1;
      sc2  <= sc1;
      tag2 <= tag1;
      p2r  <= p1r;
      p2i  <= p1i;
      rr2  <= PW'(x1r) * PW'(w1r);
      ii2  <= PW'(x1i) * PW'(w1i);
      ri2  <= PW'(x1r) * PW'(w1i);
      ir2  <= PW'(x1i) * PW'(w1r);
    end
  end

  assign re_s = SW'(rr2) - SW'(ii2);
  assign im_s = SW'(ri2) + SW'(ir2);
  assign re_r = RW'((re_s + RND) >>> (TW - 1));
  assign im_r = RW'((im_s + RND) >>> (TW - 1));
  assign c_re = clamp(OW'(re_r));
  assign c_im = clamp(OW'(im_r));

  // DIT clamps t here; DIF keeps the wide product for S4
  always_ff @(posedge clk) begin
    if (en) begin
      dif3 <= dif2;
      sc3  <= sc2;
      tag3 <= tag2;
      p3r  <= p2r;
      p3i  <= p2i;
      t3r  <= dif2 ? re_r : RW'($signed(c_re[DW-1:0]));
      t3i  <= dif2 ? im_r : RW'($signed(c_im[DW-1:0]));
      s3   <= !dif2 && (c_re[DW] || c_im[DW]);
    end
  end

  assign ya_r = dif3 ? OW'(p3r) : OW'(p3r) + OW'(t3r);
  assign ya_i = dif3 ? OW'(p3i) : OW'(p3i) + OW'(t3i);
  assign yb_r = dif3 ? OW'(t3r) : OW'(p3r) - OW'(t3r);
  assign yb_i = dif3 ? OW'(t3i) : OW'(p3i) - OW'(t3i);
  assign ca_r = conv(ya_r, sc3);
  assign ca_i = conv(ya_i, sc3);
  assign cb_r = conv(yb_r, sc3);
  assign cb_i = conv(yb_i, sc3);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      oa   <= '0;
      ob   <= '0;
      otag <= '0;
      osat <= 1'b0;
    end else if (en) begin
      oa   <= {ca_r[DW-1:0], ca_i[DW-1:0]};
      ob   <= {cb_r[DW-1:0], cb_i[DW-1:0]};
      otag <= tag3;
      osat <= s3 || ca_r[DW] || ca_i[DW] || cb_r[DW] || cb_i[DW];
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sticky <= 1'b0;
    end else if (v4 && bus.out_ready && osat) begin
      sticky <= 1'b1;
    end else if (bus.sat_clr) begin
      sticky <= 1'b0;
    end
  end

  assign bus.out_valid  = v4;
  assign bus.out_a      = oa;
  assign bus.out_b      = ob;
  assign bus.out_tag    = otag;
  assign bus.out_sat    = osat;
  assign bus.sat_sticky = sticky;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed and random stimulus against a
// sample-level arithmetic model of the butterfly pipeline.
module tb_butterfly_pipe;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int TAG_W = 8;

  typedef struct {
    logic [2*DW-1:0]  a;
    logic [2*DW-1:0]  b;
    logic [TAG_W-1:0] tag;
    bit               sat;
  } exp_t;

  logic clk = 1'b0;
  logic areset_n = 1'b1;

  butterfly_pipe_if #(.DW(DW), .TW(TW), .TAG_W(TAG_W)) bus ();

  butterfly_pipe #(.DW(DW), .TW(TW), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int   ntests = 0;
  int   nfail  = 0;
  bit   mv[4];
  exp_t me[4];
  bit   msticky = 0;
  int   got_tags[$];

  task automatic chk(string nm, logic [63:0] obs, logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  function automatic longint rnd(longint p);
    return (p + (longint'(1) << (TW - 2))) >>> (TW - 1);
  endfunction

  function automatic longint clampv(longint x, inout bit f);
    longint hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) begin f = 1; return hi; end
    if (x < lo) begin f = 1; return lo; end
    return x;
  endfunction

  function automatic longint cvt(longint x, bit sc, inout bit f);
    return clampv(sc ? (x + 1) >>> 1 : x, f);
  endfunction

  function automatic exp_t model(
    logic [2*DW-1:0] a, logic [2*DW-1:0] b, logic [2*TW-1:0] w,
    bit dif, bit inv, bit sc, logic [TAG_W-1:0] tag
  );
    exp_t e;
    bit f;
    longint ar, ai, br, bi, wr, wi, dr, di, tr, ti;
    longint yar, yai, ybr, ybi;
    f  = 0;
    ar = longint'($signed(a[2*DW-1:DW]));
    ai = longint'($signed(a[DW-1:0]));
    br = longint'($signed(b[2*DW-1:DW]));
    bi = longint'($signed(b[DW-1:0]));
    wr = longint'($signed(w[2*TW-1:TW]));
    wi = longint'($signed(w[TW-1:0]));
    if (inv) wi = -wi;
    if (!dif) begin
      tr  = clampv(rnd(br * wr - bi * wi), f);
      ti  = clampv(rnd(br * wi + bi * wr), f);
      yar = ar + tr;
      yai = ai + ti;
      ybr = ar - tr;
      ybi = ai - ti;
    end else begin
      dr  = ar - br;
      di  = ai - bi;
      yar = ar + br;
      yai = ai + bi;
      ybr = rnd(dr * wr - di * wi);
      ybi = rnd(dr * wi + di * wr);
    end
    yar = cvt(yar, sc, f);
    yai = cvt(yai, sc, f);
    ybr = cvt(ybr, sc, f);
    ybi = cvt(ybi, sc, f);
    e.a   = {DW'(yar), DW'(yai)};
    e.b   = {DW'(ybr), DW'(ybi)};
    e.tag = tag;
    e.sat = f;
    return e;
  endfunction

  function automatic logic [2*DW-1:0] pk(int re, int im);
    return {DW'(re), DW'(im)};
  endfunction

  function automatic logic [2*TW-1:0] pkw(int re, int im);
    return {TW'(re), TW'(im)};
  endfunction

  // one clock: check outputs against the model, then advance it
  task automatic cycle(output bit acc);
    bit en, dlv;
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(mv[3]));
    en = !mv[3] || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(en));
    if (mv[3]) begin
      chk("out_a", 64'(bus.out_a), 64'(me[3].a));
      chk("out_b", 64'(bus.out_b), 64'(me[3].b));
      chk("out_tag", 64'(bus.out_tag), 64'(me[3].tag));
      chk("out_sat", 64'(bus.out_sat), 64'(me[3].sat));
    end
    chk("sat_sticky", 64'(bus.sat_sticky), 64'(msticky));
    dlv = mv[3] && bus.out_ready;
    if (dlv) got_tags.push_back(int'(me[3].tag));
    if (dlv && me[3].sat) msticky = 1;
    else if (bus.sat_clr) msticky = 0;
    acc = bus.in_valid && en;
    if (en) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1];
        me[i] = me[i-1];
      end
      mv[0] = bus.in_valid;
      me[0] = model(bus.in_a, bus.in_b, bus.in_w, bus.in_dif,
                    bus.in_inv, bus.in_scale, bus.in_tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit d;
    cycle(d);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_a", 64'(bus.out_a), 64'(0));
    chk("rst_out_b", 64'(bus.out_b), 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
    chk("rst_out_sat", 64'(bus.out_sat), 64'(0));
    chk("rst_sticky", 64'(bus.sat_sticky), 64'(0));
    foreach (mv[i]) mv[i] = 0;
    msticky = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    areset_n = 1'b1;
  endtask

  task automatic drive(
    int ar, int ai, int br, int bi, int wr, int wi,
    bit dif, bit inv, bit sc, int tag
  );
    bus.in_valid = 1'b1;
    bus.in_a     = pk(ar, ai);
    bus.in_b     = pk(br, bi);
    bus.in_w     = pkw(wr, wi);
    bus.in_dif   = dif;
    bus.in_inv   = inv;
    bus.in_scale = sc;
    bus.in_tag   = TAG_W'(tag);
  endtask

  task automatic drive_rand(int tag);
    bus.in_a     = $urandom();
    bus.in_b     = $urandom();
    bus.in_w     = $urandom();
    if ($urandom_range(7) == 0) bus.in_w[2*TW-1:TW] = {1'b1, {(TW-1){1'b0}}};
    if ($urandom_range(7) == 0) bus.in_w[TW-1:0] = {1'b1, {(TW-1){1'b0}}};
    bus.in_dif   = 1'($urandom_range(1));
    bus.in_inv   = 1'($urandom_range(1));
    bus.in_scale = 1'($urandom_range(1));
    bus.in_tag   = TAG_W'(tag);
  endtask

  // single sample, exactly four cycles to out_valid, fixed expectations
  task automatic run_one(
    string nm, int ar, int ai, int br, int bi, int wr, int wi,
    bit dif, bit inv, bit sc,
    int ear, int eai, int ebr, int ebi, bit esat
  );
    drive(ar, ai, br, bi, wr, wi, dif, inv, sc, 8'h5a);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({nm, "_a"}, 64'(bus.out_a), 64'(pk(ear, eai)));
    chk({nm, "_b"}, 64'(bus.out_b), 64'(pk(ebr, ebi)));
    chk({nm, "_sat"}, 64'(bus.out_sat), 64'(esat));
    tick();
  endtask

  initial begin
    bit acc;
    int k, cyc;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_w      = '0;
    bus.in_dif    = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_scale  = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    #2;
    do_reset();
    repeat (2) tick();

    run_one("dit_neg1", 1000, 200, 300, -50, -32768, 0, 0, 0, 0,
            700, 250, 1300, 150, 0);
    run_one("dit_j", 0, 0, 100, 0, 0, -32768, 0, 0, 0,
            0, -100, 0, 100, 0);
    run_one("dit_j_inv", 0, 0, 100, 0, 0, -32768, 0, 1, 0,
            0, 100, 0, -100, 0);
    chk("sticky_clean", 64'(bus.sat_sticky), 64'(0));
    run_one("dit_sat", 32767, 0, 32767, 0, -32768, 0, 0, 0, 0,
            0, 0, 32767, 0, 1);
    chk("sticky_set", 64'(bus.sat_sticky), 64'(1));
    run_one("dit_scale", 32767, 0, 32767, 0, -32768, 0, 0, 0, 1,
            0, 0, 32767, 0, 0);
    run_one("dif", 500, -100, 100, 300, 0, -32768, 1, 0, 0,
            600, 200, -400, -400, 0);

    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sticky_clr", 64'(bus.sat_sticky), 64'(0));

    // ten tagged samples with a three-cycle output stall
    got_tags.delete();
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 100) begin
      drive_rand(k);
      bus.in_valid  = 1'b1;
      bus.out_ready = !(cyc >= 5 && cyc < 8);
      cycle(acc);
      if (acc) k++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) tick();
    chk("stream_count", 64'(got_tags.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < got_tags.size())
        chk("stream_tag", 64'(got_tags[i]), 64'(i));
    end

    // reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      drive_rand(20 + i);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    do_reset();
    repeat (6) tick();
    run_one("post_rst", 1000, 200, 300, -50, -32768, 0, 0, 0, 0,
            700, 250, 1300, 150, 0);

    // clear and saturating delivery in the same cycle
    drive(32767, 0, 32767, 0, -32768, 0, 0, 0, 0, 77);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sticky_set_wins", 64'(bus.sat_sticky), 64'(1));

    // random traffic with backpressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      drive_rand($urandom_range(255));
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      bus.sat_clr   = ($urandom_range(15) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Parametrised, fixed-point, fully pipelined radix-2 FFT butterfly. Next generation of the floating-point compute unit.
- Takes operands a, b and twiddle W, one butterfly per cycle.
- Per-sample selectable DIT/DIF ordering, inverse (conjugate-twiddle) mode, optional 1/2 scaling, saturation reporting and valid/ready backpressure.
- Sits between the stage memory reader and writer of each FFT stage.

Parameters:
DW, 16, signed width of each real/imag component of a, b and outputs.
TW, 16, signed width of each twiddle component, format Q1.(TW-1).
TAG_W, 8, width of sideband tag carried alongside each sample.

Ports:
clk  in  1  clock, rising edge.
areset_n  in  1  asynchronous active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block accepts input this cycle.
in_a  in  2*DW  operand a, {re[2DW-1:DW], im[DW-1:0]}.
in_b  in  2*DW  operand b, same packing.
in_w  in  2*TW  twiddle, same packing.
in_dif  in  1  1=DIF ordering, 0=DIT.
in_inv  in  1  1=use conj(W).
in_scale  in  1  1=divide both outputs by 2.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts output.
out_a  out  2*DW  result a, same packing.
out_b  out  2*DW  result b, same packing.
out_tag  out  TAG_W  tag of this sample.
out_sat  out  1  this sample saturated in any component.
sat_sticky  out  1  OR of out_sat over all delivered samples since reset/clear.
sat_clr  in  1  synchronous clear of sat_sticky.

Behaviour:
- Reset (areset_n low, async): all stage valid bits 0, out_valid=0, out_a=out_b=0, out_tag=0, out_sat=0, sat_sticky=0. Data in flight is discarded. Valid bits are the only state that must be reset for correctness.
- Pipeline advance: en = !out_valid | out_ready; in_ready = en. All four stages advance together when en=1 and hold when en=0 (global stall; no bubble collapse).
- Transfer rules:
  - Input is taken when in_valid & in_ready.
  - Output is delivered when out_valid & out_ready.
  - Latency is exactly 4 cycles from accept to out_valid when there is no stall.
  - Throughput is 1 sample/cycle.
- While out_valid=1 and out_ready=0, out_a, out_b, out_tag and out_sat are held stable.
- in_dif, in_inv, in_scale and in_tag are captured with the sample and travel with it, so mode may change every sample.
- Twiddle:
  - Internally Wi' = in_inv ? -Wi : Wi, held at TW+1 bits, so -(-2^(TW-1)) is exact.
  - W=-2^(TW-1) is legal and represents exactly -1.
- Complex multiply x*W:
  - re = xr*Wr - xi*Wi', im = xr*Wi' + xi*Wr, computed at full width.
  - Round half-up: add 2^(TW-2), then arithmetic shift right by TW-1.
- DIT:
  - S1 registers inputs.
  - S2 forms the products of b*W.
  - S3 sums and rounds the products, then saturates to DW to give t.
  - S4 computes out_a=a+t and out_b=a-t at DW+1 bits.
- DIF:
  - S1 computes s=a+b and d=a-b at DW+1 bits.
  - S2 and S3 form d*W and round it.
  - S4 gives out_a=s and out_b=dW.
- S4 output conversion, per component:
  - If scale=1: (x+1)>>>1, then saturate to DW.
  - If scale=0: saturate to DW.
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- Saturation flags:
  - out_sat is the OR of every saturation event on that sample, including the S3 product saturation.
  - sat_sticky is set on each delivered sample with out_sat=1.
  - sat_clr=1 clears sat_sticky. If set and clear occur in the same cycle, set wins.
- Reset mid-stream: after areset_n returns high, the first out_valid appears exactly 4 accepted-and-advanced cycles after the first post-reset input.

Test Plan (DW=TW=16):
- DIT, a=(1000,200), b=(300,-50), W=(-32768,0), inv=0, scale=0 -> 4 cycles later out_a=(700,250), out_b=(1300,150), out_sat=0.
- DIT, a=(0,0), b=(100,0), W=(0,-32768): inv=0 -> out_a=(0,-100), out_b=(0,100); same sample with inv=1 -> out_a=(0,100), out_b=(0,-100).
- DIT, a=(32767,0), b=(32767,0), W=(-32768,0):
  - scale=0 -> out_a=(0,0), out_b=(32767,0), out_sat=1, sat_sticky=1.
  - scale=1 -> out_b=(32767,0), out_sat=0.
- DIF, a=(500,-100), b=(100,300), W=(0,-32768), scale=0 -> out_a=(600,200), out_b=(-400,-400).
- Stream 10 samples with tags 0..9 and drop out_ready for 3 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 10 delivered in order with matching tags and no duplicates.
- Assert areset_n low with 3 samples in flight -> out_valid=0 immediately and no stale samples appear afterwards. Then pulse sat_clr together with a saturating delivery -> sat_sticky remains 1.
